// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector serializer slice.
// Element type and serializer state encoding.
package vec_pkg;

    localparam int BITS_DEF = 8;
    localparam int N_DEF    = 64;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } ser_state_t;

    typedef logic [BITS_DEF-1:0] elem_t;

endpackage

// File: rtl/vec_elem_mux.sv
// N:1 selector of one snapshot lane.
// Output is forced to zero when the selection is not valid.
module vec_elem_mux
    import vec_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int N    = N_DEF,
    parameter int IW   = $clog2(N)
) (
    input  logic [BITS-1:0] snap [N-1:0],
    input  logic [IW-1:0]   sel,
    input  logic            valid,
    output logic [BITS-1:0] data
);

    always_comb begin
        data = '0;
        if (valid) begin
            data = snap[sel];
        end
    end

endmodule

// File: rtl/vector_serializer.sv
// Snapshots an N-lane vector on start and streams lanes 0..len-1
// one element per accepted valid/ready beat.
module vector_serializer
    import vec_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int N    = N_DEF,
    parameter int LW   = $clog2(N+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BITS-1:0]      vec_in [N-1:0],
    input  logic                 start,
    input  logic [LW-1:0]        len,
    output logic                 busy,
    output logic                 done,
    output logic [BITS-1:0]      out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_index
);

    localparam int IW = $clog2(N);

    ser_state_t      state;
    ser_state_t      nstate;
    logic [IW-1:0]   idx;
    logic [LW-1:0]   cnt_len;
    logic [BITS-1:0] snap [N-1:0];

    logic [LW-1:0]   len_clamp;
    logic            last_hit;
    logic            capture;
    logic            advance;

    assign len_clamp = (len > LW'(N)) ? LW'(N) : len;
    assign last_hit  = (LW'(idx) == (cnt_len - LW'(1)));

    // Outputs decode only from registered state, never from out_ready.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = (state == STREAM);
    assign out_last  = out_valid && last_hit;
    assign out_index = out_valid ? idx : '0;

    always_comb begin
        nstate  = state;
        capture = 1'b0;
        advance = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    nstate  = (len_clamp == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (last_hit) begin
                        nstate = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                nstate = IDLE;
            end
            default: begin
                nstate = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt_len <= '0;
            for (int i = 0; i < N; i++) begin
                snap[i] <= '0;
            end
        end else begin
            state <= nstate;
            if (capture) begin
                snap    <= vec_in;
                cnt_len <= len_clamp;
                idx     <= '0;
            end else if (advance) begin
                idx <= idx + IW'(1);
            end
        end
    end

    vec_elem_mux #(
        .BITS (BITS),
        .N    (N),
        .IW   (IW)
    ) u_mux (
        .snap  (snap),
        .sel   (idx),
        .valid (out_valid),
        .data  (out_data)
    );

endmodule

// File: tb/tb_vector_serializer.sv
// Directed bench for vector_serializer with hand-computed expectations.
// Checks reset, streaming, clamping, stalls, abort and back-to-back starts.
module tb_vector_serializer;

    localparam int BITS = 8;
    localparam int N    = 64;
    localparam int LW   = 7;

    logic            clk;
    logic            rst_n;
    logic [BITS-1:0] vec_in [N-1:0];
    logic            start;
    logic [LW-1:0]   len;
    logic            busy;
    logic            done;
    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [5:0]      out_index;

    logic [BITS-1:0] expv [N-1:0];

    int checks = 0;
    int errors = 0;

    vector_serializer #(
        .BITS (BITS),
        .N    (N),
        .LW   (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_in    (vec_in),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int l);
        start = 1'b1;
        len   = LW'(l);
        step();
        start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_index"}, 32'(out_index), 0);
    endtask

    // Receive L beats of expv; optional random ready and start poke.
    task automatic recv(input string tag, input int l,
                        input bit rnd, input bit poke);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < l && cyc < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (poke && k == 1) ? 1'b1 : 1'b0;
            len   = poke ? LW'(9) : len;
            chk({tag, "_valid"}, 32'(out_valid), 1);
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_data"}, 32'(out_data), 32'(expv[k]));
            chk({tag, "_index"}, 32'(out_index), 32'(k));
            chk({tag, "_last"}, 32'(out_last), 32'(k == l - 1));
            step();
            if (out_ready) k++;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_beats"}, 32'(k), 32'(l));
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_dvalid"}, 32'(out_valid), 0);
        chk({tag, "_ddata"}, 32'(out_data), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(i + 'h10);
        #12;
        chk_idle("reset");
        rst_n = 1'b1;
        step();

        // len=4, ready high
        for (int i = 0; i < N; i++) expv[i] = BITS'(i + 'h10);
        go(4);
        recv("len4", 4, 1'b0, 1'b0);
        chk("len4_dbusy", 32'(busy), 1);
        step();
        chk_idle("len4_after");

        // len=64, random stalls, source overwritten after capture
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(8'hA0 ^ i);
        for (int i = 0; i < N; i++) expv[i] = BITS'(8'hA0 ^ i);
        go(64);
        for (int i = 0; i < N; i++) vec_in[i] = 8'hFF;
        recv("full", 64, 1'b1, 1'b0);
        step();
        chk_idle("full_after");

        // len=0 goes straight to DONE
        go(0);
        chk("len0_busy", 32'(busy), 1);
        chk("len0_done", 32'(done), 1);
        chk("len0_valid", 32'(out_valid), 0);
        step();
        chk_idle("len0_after");

        // len=100 clamps to 64 beats
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(3 * i + 1);
        for (int i = 0; i < N; i++) expv[i] = BITS'(3 * i + 1);
        go(100);
        recv("clamp", 64, 1'b0, 1'b0);
        step();
        chk_idle("clamp_after");

        // start during STREAM is ignored
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(8'h55 + i);
        for (int i = 0; i < N; i++) expv[i] = BITS'(8'h55 + i);
        go(4);
        recv("poke", 4, 1'b0, 1'b1);
        step();
        chk_idle("poke_after");

        // asynchronous reset mid-transfer
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(8'h80 + i);
        go(8);
        step();
        step();
        chk("abort_pre_data", 32'(out_data), 32'h82);
        chk("abort_pre_index", 32'(out_index), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(8'hC0 + i);
        for (int i = 0; i < N; i++) expv[i] = BITS'(8'hC0 + i);
        #3;
        rst_n = 1'b1;
        step();
        chk_idle("abort_rel");
        go(2);
        recv("fresh", 2, 1'b0, 1'b0);
        step();

        // back-to-back: element 0 two cycles after first done
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(8'h20 + i);
        for (int i = 0; i < N; i++) expv[i] = BITS'(8'h20 + i);
        go(3);
        recv("b2b_a", 3, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) vec_in[i] = BITS'(8'h40 + i);
        for (int i = 0; i < N; i++) expv[i] = BITS'(8'h40 + i);
        step();
        chk_idle("b2b_gap");
        go(2);
        recv("b2b_b", 2, 1'b0, 1'b0);
        step();
        chk_idle("b2b_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
